// File: rtl/acc_wbuf_pkg.sv
// Shared constants, address field positions, read-FSM states and the
// word-index helper for the ping-pong weight buffer.
package acc_wbuf_pkg;

    localparam int WBUF_WORDS    = 160;
    localparam int WBUF_1X1_BASE = 144;
    localparam int WBUF_NPOS     = 9;
    localparam int WBUF_NVEC     = 10;

    localparam int KSEL   = 31;
    localparam int OCH_HI = 30;
    localparam int OCH_LO = 23;
    localparam int POS_HI = 11;
    localparam int POS_LO = 6;
    localparam int CH_HI  = 5;
    localparam int CH_LO  = 0;

    typedef enum logic {
        RD_IDLE,
        RD_STREAM
    } rd_state_t;

    // 3x3 words sit at pos*16+ch, the 1x1 row follows the nine kernel rows.
    function automatic logic [7:0] wordIndex(input logic       ksel,
                                             input logic [3:0] pos,
                                             input logic [3:0] ch);
        logic [7:0] idx;
        if (ksel) idx = 8'(WBUF_1X1_BASE) + {4'b0000, ch};
        else      idx = {pos, ch};
        return idx;
    endfunction

endpackage

// File: rtl/wbuf_bank.sv
// One weight bank: 160 words, a single write port and a combinational
// read port returning one 16-word row (kernel position) at a time.
module wbuf_bank
    import acc_wbuf_pkg::*;
#(
    parameter int DW  = 32,
    parameter int NCH = 16
) (
    input  logic              clk,
    input  logic              i_wen,
    input  logic [7:0]        i_widx,
    input  logic [DW-1:0]     i_wdata,
    input  logic [3:0]        i_row,
    output logic [NCH*DW-1:0] o_row
);

    logic [DW-1:0] r_mem [WBUF_WORDS];

    // Storage is deliberately left unreset; the full flag guards its validity.
    always_ff @(posedge clk) begin
        if (i_wen) r_mem[i_widx] <= i_wdata;
    end

    // Gather the NCH consecutive words that make up the selected row.
    always_comb begin
        o_row = '0;
        for (int c = 0; c < NCH; c++) begin
            o_row[c*DW +: DW] = r_mem[8'(int'(i_row) * NCH + c)];
        end
    end

endmodule

// File: rtl/weight_buf.sv
// Ping-pong weight buffer: fills one bank from the weight write stream while
// the other bank is replayed to the MAC array as ten 16-channel vectors.
module weight_buf
    import acc_wbuf_pkg::*;
#(
    parameter int DW   = 32,
    parameter int NCH  = 16,
    parameter int NPOS = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       weight_waddr,
    input  logic [DW-1:0]     weight_wdata,
    input  logic              weight_wen,
    output logic              wbuf_free,
    output logic              wbuf_err,
    output logic              wv_vld,
    input  logic              wv_rdy,
    output logic [NCH*DW-1:0] wv_data,
    output logic [3:0]        wv_pos,
    output logic              wv_last,
    output logic [7:0]        wv_och,
    input  logic              mac_release
);

    logic [1:0]        r_full;
    logic              r_wrPtr;
    logic              r_rdPtr;
    logic [7:0]        r_wcnt;
    logic [7:0]        r_och [2];
    logic              r_err;
    rd_state_t         r_state;
    rd_state_t         w_nextState;
    logic              r_vld;
    logic [NCH*DW-1:0] r_data;
    logic [3:0]        r_pos;
    logic              r_last;
    logic [7:0]        r_vecOch;

    logic              w_ksel;
    logic [5:0]        w_pos;
    logic [5:0]        w_chField;
    logic [7:0]        w_och;
    logic [7:0]        w_widx;
    logic              w_illegal;
    logic              w_wrFull;
    logic              w_accept;
    logic              w_drop;
    logic              w_fillDone;
    logic              w_release;
    logic              w_load;
    logic              w_clrVld;
    logic [3:0]        w_loadPos;
    logic [NCH*DW-1:0] w_row [2];
    logic              w_unused;

    assign w_ksel     = weight_waddr[KSEL];
    assign w_pos      = weight_waddr[POS_HI:POS_LO];
    assign w_chField  = weight_waddr[CH_HI:CH_LO];
    assign w_och      = weight_waddr[OCH_HI:OCH_LO];
    assign w_unused   = ^{weight_waddr[OCH_LO-1:POS_HI+1], w_chField[5:4]};
    assign w_widx     = wordIndex(w_ksel, w_pos[3:0], w_chField[3:0]);
    assign w_illegal  = ~w_ksel & (w_pos >= 6'(NPOS));
    assign w_wrFull   = r_full[r_wrPtr];
    assign w_accept   = weight_wen & ~w_wrFull & ~w_illegal;
    assign w_drop     = weight_wen & (w_wrFull | w_illegal);
    assign w_fillDone = w_accept & (r_wcnt == 8'(WBUF_WORDS - 1));
    assign w_release  = mac_release & r_full[r_rdPtr];

    assign wbuf_free  = ~r_full[r_wrPtr];
    assign wbuf_err   = r_err;
    assign wv_vld     = r_vld;
    assign wv_data    = r_data;
    assign wv_pos     = r_pos;
    assign wv_last    = r_last;
    assign wv_och     = r_vecOch;

    for (genvar gb = 0; gb < 2; gb++) begin : g_bank
        wbuf_bank #(.DW(DW), .NCH(NCH)) u_bank (
            .clk    (clk),
            .i_wen  (w_accept && (r_wrPtr == 1'(gb))),
            .i_widx (w_widx),
            .i_wdata(weight_wdata),
            .i_row  (w_loadPos),
            .o_row  (w_row[gb])
        );
    end

    // Fill side: count accepted words, latch the channel on the first word, flip banks after the last.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wcnt  <= '0;
            r_wrPtr <= 1'b0;
            r_err   <= 1'b0;
            r_och   <= '{default: '0};
        end else begin
            if (w_accept) begin
                if (r_wcnt == '0) r_och[r_wrPtr] <= w_och;
                if (w_fillDone) begin
                    r_wcnt  <= '0;
                    r_wrPtr <= ~r_wrPtr;
                end else begin
                    r_wcnt <= r_wcnt + 8'd1;
                end
            end
            if (w_drop) r_err <= 1'b1;
        end
    end

    // Full flags: a fill completion and a release only ever target opposite banks.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_full  <= '0;
            r_rdPtr <= 1'b0;
        end else begin
            for (int b = 0; b < 2; b++) begin
                if (w_fillDone && (r_wrPtr == 1'(b)))      r_full[b] <= 1'b1;
                else if (w_release && (r_rdPtr == 1'(b)))  r_full[b] <= 1'b0;
            end
            if (w_release) r_rdPtr <= ~r_rdPtr;
        end
    end

    // Read FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= RD_IDLE;
        else        r_state <= w_nextState;
    end

    // Read FSM next state and vector-load decision; release outranks a handshake.
    always_comb begin
        w_nextState = r_state;
        w_load      = 1'b0;
        w_clrVld    = 1'b0;
        w_loadPos   = r_pos;
        if (w_release) begin
            w_nextState = RD_IDLE;
            w_clrVld    = 1'b1;
        end else begin
            case (r_state)
                RD_IDLE: begin
                    if (r_full[r_rdPtr]) begin
                        w_load      = 1'b1;
                        w_loadPos   = 4'd0;
                        w_nextState = RD_STREAM;
                    end
                end
                RD_STREAM: begin
                    if (r_vld && wv_rdy) begin
                        w_load    = 1'b1;
                        w_loadPos = (r_pos == 4'(WBUF_NVEC - 1)) ? 4'd0 : r_pos + 4'd1;
                    end
                end
                default: w_nextState = RD_IDLE;
            endcase
        end
    end

    // Output vector registers; held unchanged whenever nothing is loaded.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_vld    <= 1'b0;
            r_data   <= '0;
            r_pos    <= '0;
            r_last   <= 1'b0;
            r_vecOch <= '0;
        end else if (w_clrVld) begin
            r_vld  <= 1'b0;
            r_pos  <= '0;
            r_last <= 1'b0;
        end else if (w_load) begin
            r_vld    <= 1'b1;
            r_data   <= w_row[r_rdPtr];
            r_pos    <= w_loadPos;
            r_last   <= (w_loadPos == 4'(WBUF_NPOS));
            r_vecOch <= r_och[r_rdPtr];
        end
    end

endmodule
